// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_DATA  = 2'd2
  } arb_grant_e;

  localparam int DEF_ADDR_W      = 64;
  localparam int DEF_DATA_W      = 64;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/arb_timeout_counter.sv
// Cycle counter for a pending memory request; tc_o flags the last permitted cycle.
module arb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The count starts at 0 in the first m_req cycle, so LIMIT-1 marks cycle LIMIT.
  assign tc_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (data over fetch) arbiter sharing one variable-latency memory port.
// Optional request timeout enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err,
  output logic              err_sticky
);

  arb_state_e        state_q;
  arb_grant_e        gnt_q;
  logic              m_req_q, m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic              if_ready_q, d_ready_q;
  logic [31:0]       if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              take_d, take_if;

  // In RESP the requester just served is masked so it cannot be granted twice.
  always_comb begin
    take_d  = 1'b0;
    take_if = 1'b0;
    case (state_q)
      IDLE: begin
        take_d  = d_req;
        take_if = if_req && !d_req;
      end
      RESP: begin
        take_d  = d_req && (gnt_q != GNT_DATA);
        take_if = if_req && (gnt_q != GNT_FETCH) && !take_d;
      end
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic tmo_w;
  logic err_q, err_sticky_q;

  arb_timeout_counter #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != BUSY),
    .en_i  ((state_q == BUSY) && !m_ack),
    .tc_o  (tmo_w)
  );

  assign err        = err_q;
  assign err_sticky = err_sticky_q;
`else
  assign err        = 1'b0;
  assign err_sticky = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_NONE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
`endif
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state_q)
        BUSY: begin
          if (m_ack) begin
            state_q <= RESP;
            m_req_q <= 1'b0;
            if (gnt_q == GNT_FETCH) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= m_rdata[31:0];
            end else begin
              d_ready_q <= 1'b1;
              if (!m_we_q) d_rdata_q <= m_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
          // A timed-out access completes with zeroed read data and an error flag.
          else if (tmo_w) begin
            state_q      <= RESP;
            m_req_q      <= 1'b0;
            err_q        <= 1'b1;
            err_sticky_q <= 1'b1;
            if (gnt_q == GNT_FETCH) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= '0;
            end else begin
              d_ready_q <= 1'b1;
              d_rdata_q <= '0;
            end
          end
`endif
        end
        default: begin
          if (take_d) begin
            state_q   <= BUSY;
            gnt_q     <= GNT_DATA;
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
          end else if (take_if) begin
            state_q   <= BUSY;
            gnt_q     <= GNT_FETCH;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= if_addr;
            m_wdata_q <= '0;
          end else begin
            state_q <= IDLE;
            gnt_q   <= GNT_NONE;
          end
        end
      endcase
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_ready = if_ready_q;
  assign if_rdata = if_rdata_q;
  assign d_ready  = d_ready_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, variable-latency memory between the CPU_64bit instruction-fetch path and the load/store data path. It grants one requester at a time and drives the memory request/acknowledge handshake. It registers the read data back to the granted requester. It lets the CPU move from a split instruction/data memory to a unified memory.

## Interface
- ADDR_W, 64, address width for both requesters and the memory port
- DATA_W, 64, memory data width
- TIMEOUT_CYC, 255, maximum cycles `m_req` is held without `m_ack` (used only with ARB_TIMEOUT_EN)
- clk  in  1  system clock; everything changes on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with `if_addr` stable until `if_ready`
- if_addr  in  ADDR_W  fetch byte address
- if_ready  out  1  one-cycle pulse; the fetch is complete
- if_rdata  out  32  instruction, taken from the low 32 bits of `m_rdata`
- d_req  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` stable until `d_ready`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse; the data access is complete
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory request; held until `m_ack` (or timeout)
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_ack  in  1  one-cycle pulse from memory; `m_rdata` is valid in the same cycle
- m_rdata  in  DATA_W  memory read data
- err  out  1  one-cycle pulse together with `if_ready`/`d_ready` when the access timed out
- err_sticky  out  1  set by any timeout; cleared only by reset

## Operation
- States:
  - IDLE: no grant.
  - BUSY: `m_req` is high for the granted requester.
  - RESP: one cycle; the granted requester's `*_ready` is high.
- Priority is fixed: data over fetch.
- Grant:
  - On the edge leaving IDLE with a request pending, the arbiter registers grant, `m_addr`, `m_we` and `m_wdata`, and sets `m_req=1`.
  - A fetch grant always has `m_we=0` and `m_wdata=0`.
- BUSY → RESP:
  - Taken on the edge where `m_ack=1` is sampled.
  - `m_req` drops and the requester's `*_rdata` captures `m_rdata`.
  - For stores, `d_rdata` is left unchanged.
- RESP:
  - The requester just served has its `*_req` ignored in this cycle, which prevents a duplicate grant.
  - If the other requester's request is pending, go directly to BUSY for it; otherwise go to IDLE.
- `*_rdata` holds its value until that requester's next completion.
- `m_ack` arriving in IDLE or RESP is ignored.
- Reset values:
  - state IDLE, grant none.
  - `m_req`, `m_we`, `if_ready`, `d_ready`, `err`, `err_sticky` = 0.
  - `m_addr`, `m_wdata`, `if_rdata`, `d_rdata` = 0.
- Reset mid-access: the access is abandoned with no ready pulse. The requester must re-present it.

## Timing
- Request sampled in cycle N:
  - `m_req` goes high in N+1.
  - `m_ack` can arrive in N+k, k≥1.
  - `*_ready` is high in N+k+1.
  - Minimum latency is 2 cycles.
- Same requester back-to-back: request, IDLE, re-grant. A minimum of 3 cycles per access.
- Alternating requesters: RESP hands over directly, so the next `m_req` rises in the cycle after RESP.
- A fetch pending while data is in BUSY waits. A new data request arriving during RESP of a fetch still wins the next grant.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter clears on each grant and increments every BUSY cycle without `m_ack`.
  - When `m_req` has been high TIMEOUT_CYC cycles with no ack, go to RESP anyway: `*_ready=1`, `err=1`, `*_rdata=0`, `err_sticky` set.
  - An `m_ack` in the same cycle as the final count wins, so there is no error.
- ARB_TIMEOUT_EN undefined: BUSY waits indefinitely; `err` and `err_sticky` are tied to 0. The ports remain.

## Structure
- Package `mem_arb_pkg` contains:
  - `arb_state_e` {IDLE, BUSY, RESP}
  - `arb_grant_e` {GNT_NONE, GNT_FETCH, GNT_DATA}
  - the default width constants
- Sub-module `arb_timeout_counter` (clear, enable, terminal-count output) is instantiated only under ARB_TIMEOUT_EN.

## Test plan
- Reset, then release: every output is 0 and the state is IDLE. `m_ack` pulsed while idle → no ready, no `m_req`.
- Fetch `if_addr=0x40`, memory acks one cycle after `m_req` with `m_rdata=0x0000_0000_D503201F` → `m_req` high 1 cycle, `m_we=0`, `if_ready` 2 cycles after request, `if_rdata=0xD503201F`.
- `if_req` and `d_req` (load 0x100) asserted in the same cycle, ack latency 3 → data served first, `d_rdata` = ack data. The fetch `m_req` rises the cycle after `d_ready`; `if_ready` follows 4 cycles later.
- Store `d_addr=0x200`, `d_wdata=0xDEADBEEF_00000000` → `m_we=1` with exact address and data while `m_req` is high. `d_ready` after ack; `d_rdata` unchanged.
- Reset asserted while BUSY → `m_req` 0 on that edge, no `*_ready`. A request re-presented afterwards completes normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=8, memory never acks → `m_req` high exactly 8 cycles, then `d_ready=1`, `err=1`, `d_rdata=0`. `err_sticky` stays 1 until reset.
